// File: rtl/seg_display_engine.sv
// seg_display_engine: N-digit multiplexed 7-segment driver.
// A latched value is converted to BCD with a one-bit-per-cycle double-dabble,
// or shown directly as hex nibbles. The scan adds overflow dashes,
// leading-zero blanking, decimal points, per-digit blink and PWM brightness.
module seg_display_engine #(
    parameter int NUM_DIGITS      = 4,
    parameter int BIN_WIDTH       = 16,
    parameter int REFRESH_DIVIDER = 100000,
    parameter int BRIGHT_BITS     = 4,
    parameter int BLINK_SCANS     = 125
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [BIN_WIDTH-1:0]   value,
    input  logic                   load,
    input  logic                   hex_mode,
    input  logic                   blank_lz,
    input  logic [NUM_DIGITS-1:0]  dp_mask,
    input  logic [NUM_DIGITS-1:0]  blink_mask,
    input  logic [BRIGHT_BITS-1:0] brightness,
    output logic                   busy,
    output logic [6:0]             seg,
    output logic [NUM_DIGITS-1:0]  an,
    output logic                   dp
);

    localparam int DW      = 4 * NUM_DIGITS;
    localparam int SLOT_W  = (NUM_DIGITS > 1)      ? $clog2(NUM_DIGITS)      : 1;
    localparam int REF_W   = (REFRESH_DIVIDER > 1) ? $clog2(REFRESH_DIVIDER) : 1;
    localparam int FRAME_W = (BLINK_SCANS > 1)     ? $clog2(BLINK_SCANS)     : 1;
    localparam int CNT_W   = (BIN_WIDTH > 1)       ? $clog2(BIN_WIDTH)       : 1;
    localparam int EXT_W   = (BIN_WIDTH > DW)      ? BIN_WIDTH               : DW;

    typedef enum logic {IDLE, CONV} state_t;

    state_t               state, state_next;
    logic [BIN_WIDTH-1:0] bin_sr;
    logic [DW-1:0]        bcd, bcd_adj, bcd_next;
    logic                 conv_ovf, ovf_next;
    logic [CNT_W-1:0]     bit_cnt;
    logic                 conv_last;

    logic [DW-1:0]        disp_digits;
    logic                 disp_ovf;
    logic [EXT_W-1:0]     value_ext;
    logic                 hex_ovf;

    logic [REF_W-1:0]       ref_cnt;
    logic [SLOT_W-1:0]      slot;
    logic [FRAME_W-1:0]     frame_cnt;
    logic                   blink_on;
    logic [BRIGHT_BITS-1:0] pwm_cnt;

    logic [3:0]            cur_digit;
    logic                  cur_dp, cur_blink, upper_clear, lz_blank, anode_on;
    logic [NUM_DIGITS-1:0] an_sel, an_next;
    logic [6:0]            seg_next;
    logic                  dp_next;

    function automatic logic [6:0] glyph(input logic [3:0] n);
        case (n)
            4'h0: glyph = 7'b1000000;
            4'h1: glyph = 7'b1111001;
            4'h2: glyph = 7'b0100100;
            4'h3: glyph = 7'b0110000;
            4'h4: glyph = 7'b0011001;
            4'h5: glyph = 7'b0010010;
            4'h6: glyph = 7'b0000010;
            4'h7: glyph = 7'b1111000;
            4'h8: glyph = 7'b0000000;
            4'h9: glyph = 7'b0010000;
            4'hA: glyph = 7'b0001000;
            4'hB: glyph = 7'b0000011;
            4'hC: glyph = 7'b1000110;
            4'hD: glyph = 7'b0100001;
            4'hE: glyph = 7'b0000110;
            default: glyph = 7'b0001110;
        endcase
    endfunction

    assign busy      = (state == CONV);
    assign conv_last = (bit_cnt == CNT_W'(BIN_WIDTH - 1));
    assign value_ext = EXT_W'(value);
    // Any nonzero nibble beyond the display width is an overflow; missing nibbles are zero.
    assign hex_ovf   = (value_ext >> DW) != '0;

    // Conversion FSM state register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state: decimal capture starts CONV, which lasts exactly BIN_WIDTH cycles.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (load && !hex_mode) state_next = CONV;
            CONV:    if (conv_last)         state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // One double-dabble step: add 3 to every digit >= 5, then shift in the next MSB.
    always_comb begin
        bcd_adj = bcd;
        for (int unsigned d = 0; d < NUM_DIGITS; d++) begin
            if (bcd[4*d +: 4] >= 4'd5) bcd_adj[4*d +: 4] = bcd[4*d +: 4] + 4'd3;
        end
        bcd_next = {bcd_adj[DW-2:0], bin_sr[BIN_WIDTH-1]};
        ovf_next = conv_ovf | bcd_adj[DW-1];
    end

    // Capture, conversion datapath and the atomically updated display register.
    always_ff @(posedge clk) begin
        if (rst) begin
            bin_sr      <= '0;
            bcd         <= '0;
            conv_ovf    <= 1'b0;
            bit_cnt     <= '0;
            disp_digits <= '0;
            disp_ovf    <= 1'b0;
        end else if (state == IDLE) begin
            if (load) begin
                if (hex_mode) begin
                    disp_digits <= value_ext[DW-1:0];
                    disp_ovf    <= hex_ovf;
                end else begin
                    bin_sr   <= value;
                    bcd      <= '0;
                    conv_ovf <= 1'b0;
                    bit_cnt  <= '0;
                end
            end
        end else begin
            bin_sr   <= bin_sr << 1;
            bcd      <= bcd_next;
            conv_ovf <= ovf_next;
            bit_cnt  <= bit_cnt + CNT_W'(1);
            if (conv_last) begin
                disp_digits <= bcd_next;
                disp_ovf    <= ovf_next;
            end
        end
    end

    // Refresh divider, slot index, frame counter, blink phase and PWM counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            ref_cnt   <= '0;
            slot      <= '0;
            frame_cnt <= '0;
            blink_on  <= 1'b1;
            pwm_cnt   <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + BRIGHT_BITS'(1);
            if (ref_cnt == REF_W'(REFRESH_DIVIDER - 1)) begin
                ref_cnt <= '0;
                if (slot == SLOT_W'(NUM_DIGITS - 1)) begin
                    slot <= '0;
                    if (frame_cnt == FRAME_W'(BLINK_SCANS - 1)) begin
                        frame_cnt <= '0;
                        blink_on  <= ~blink_on;
                    end else begin
                        frame_cnt <= frame_cnt + FRAME_W'(1);
                    end
                end else begin
                    slot <= slot + SLOT_W'(1);
                end
            end else begin
                ref_cnt <= ref_cnt + REF_W'(1);
            end
        end
    end

    // Per-slot decode: overflow, then blink, then leading-zero blank, then glyph.
    always_comb begin
        cur_digit   = '0;
        cur_dp      = 1'b0;
        cur_blink   = 1'b0;
        upper_clear = 1'b1;
        an_sel      = '0;
        for (int unsigned d = 0; d < NUM_DIGITS; d++) begin
            if (SLOT_W'(d) == slot) begin
                cur_digit = disp_digits[4*d +: 4];
                cur_dp    = dp_mask[d];
                cur_blink = blink_mask[d];
                an_sel[d] = 1'b1;
            end
            if (SLOT_W'(d) >= slot && (disp_digits[4*d +: 4] != 4'd0 || dp_mask[d]))
                upper_clear = 1'b0;
        end
        lz_blank = blank_lz && (slot != '0) && upper_clear;
        anode_on = (pwm_cnt <= brightness);

        seg_next = '1;
        an_next  = '1;
        dp_next  = 1'b1;
        if (disp_ovf) begin
            seg_next = 7'b0111111;
            if (anode_on) an_next = ~an_sel;
        end else if (!blink_on && cur_blink) begin
            seg_next = '1;
        end else if (lz_blank) begin
            seg_next = '1;
        end else begin
            seg_next = glyph(cur_digit);
            dp_next  = ~cur_dp;
            if (anode_on) an_next = ~an_sel;
        end
    end

    // Registered display pins.
    always_ff @(posedge clk) begin
        if (rst) begin
            seg <= '1;
            an  <= '1;
            dp  <= 1'b1;
        end else begin
            seg <= seg_next;
            an  <= an_next;
            dp  <= dp_next;
        end
    end

endmodule

// File: tb/tb_seg_display_engine.sv
// Directed self-checking bench for seg_display_engine (4-digit main instance,
// plus a 3-digit instance to exercise hex nibbles beyond the display width).
module tb_seg_display_engine;

    localparam logic [6:0] G0   = 7'b1000000;
    localparam logic [6:0] G1   = 7'b1111001;
    localparam logic [6:0] G2   = 7'b0100100;
    localparam logic [6:0] G3   = 7'b0110000;
    localparam logic [6:0] G4   = 7'b0011001;
    localparam logic [6:0] G7   = 7'b1111000;
    localparam logic [6:0] GB   = 7'b0000011;
    localparam logic [6:0] GE   = 7'b0000110;
    localparam logic [6:0] GF   = 7'b0001110;
    localparam logic [6:0] DASH = 7'b0111111;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] value;
    logic        load, hex_mode, blank_lz;
    logic [3:0]  dp_mask, blink_mask, brightness;
    logic        busy, dp;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        busy3, dp3;
    logic [6:0]  seg3;
    logic [2:0]  an3;

    int checks = 0;
    int errors = 0;

    seg_display_engine #(
        .NUM_DIGITS(4), .BIN_WIDTH(16), .REFRESH_DIVIDER(4),
        .BRIGHT_BITS(4), .BLINK_SCANS(2)
    ) dut (
        .clk(clk), .rst(rst), .value(value), .load(load), .hex_mode(hex_mode),
        .blank_lz(blank_lz), .dp_mask(dp_mask), .blink_mask(blink_mask),
        .brightness(brightness), .busy(busy), .seg(seg), .an(an), .dp(dp)
    );

    seg_display_engine #(
        .NUM_DIGITS(3), .BIN_WIDTH(16), .REFRESH_DIVIDER(4),
        .BRIGHT_BITS(4), .BLINK_SCANS(2)
    ) dut3 (
        .clk(clk), .rst(rst), .value(value), .load(load), .hex_mode(hex_mode),
        .blank_lz(blank_lz), .dp_mask(dp_mask[2:0]), .blink_mask(blink_mask[2:0]),
        .brightness(brightness), .busy(busy3), .seg(seg3), .an(an3), .dp(dp3)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, time %0t", $time);
        $fatal(1, "timeout");
    end

    // Wait (bounded) for a given anode pattern, sampled on the falling edge.
    task automatic wait_an(input logic [3:0] pat, output bit found);
        found = 1'b0;
        for (int i = 0; i < 64 && !found; i++) begin
            @(negedge clk);
            if (an === pat) found = 1'b1;
        end
    endtask

    task automatic wait_idle(output bit found);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (busy === 1'b0) found = 1'b1;
        end
    endtask

    task automatic test_reset;
        bit found;
        repeat (3) @(negedge clk);
        checks++;
        if (an !== 4'hF || seg !== 7'h7F || dp !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: an=%h seg=%h dp=%b busy=%b, expected an=f seg=7f dp=1 busy=0",
                     an, seg, dp, busy);
        end
        rst = 1'b0;
        wait_an(4'b1110, found);
        checks++;
        if (!found || seg !== G0 || dp !== 1'b1) begin
            errors++;
            $display("FAIL reset_display_zero: found=%b seg=%b dp=%b, expected seg=%b dp=1", found, seg, dp, G0);
        end
    endtask

    task automatic test_decimal_1234;
        int bad_busy = 0;
        int bad_old  = 0;
        bit found;
        logic [6:0] exp_g [4];
        exp_g[0] = G4; exp_g[1] = G3; exp_g[2] = G2; exp_g[3] = G1;
        @(negedge clk);
        value = 16'd1234; hex_mode = 1'b0; load = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 16; k++) begin
            if (busy !== 1'b1) bad_busy++;
            if (an !== 4'hF && seg !== G0) bad_old++;
            // k=4: load sampled at T+5; k=15: load coincides with conversion end.
            load     = (k == 4 || k == 15);
            hex_mode = (k == 15);
            value    = (k == 15) ? 16'hAAAA : 16'd9999;
            @(negedge clk);
        end
        load = 1'b0; hex_mode = 1'b0;
        checks++;
        if (bad_busy != 0) begin
            errors++;
            $display("FAIL dec_busy_window: %0d of 16 cycles without busy, expected 0", bad_busy);
        end
        checks++;
        if (bad_old != 0) begin
            errors++;
            $display("FAIL dec_old_value_shown: %0d cycles not showing old 0, expected 0", bad_old);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL dec_busy_end: busy=%b at T+17, expected 0", busy);
        end
        @(negedge clk);
        for (int s = 0; s < 4; s++) begin
            wait_an(4'(~(4'b0001 << s)), found);
            checks++;
            if (!found || seg !== exp_g[s] || dp !== 1'b1) begin
                errors++;
                $display("FAIL dec_1234_slot%0d: found=%b seg=%b dp=%b, expected seg=%b dp=1",
                         s, found, seg, dp, exp_g[s]);
            end
        end
    endtask

    task automatic test_decimal_overflow;
        bit found;
        @(negedge clk);
        value = 16'd12345; hex_mode = 1'b0; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        wait_idle(found);
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL ovf_busy_drop: busy still %b after 40 cycles, expected 0", busy);
        end
        @(negedge clk);
        for (int s = 0; s < 4; s++) begin
            wait_an(4'(~(4'b0001 << s)), found);
            checks++;
            if (!found || seg !== DASH || dp !== 1'b1) begin
                errors++;
                $display("FAIL ovf_slot%0d: found=%b seg=%b dp=%b, expected seg=%b dp=1",
                         s, found, seg, dp, DASH);
            end
        end
    endtask

    task automatic test_leading_zero;
        bit found;
        int bad = 0;
        int n0  = 0;
        int cnt [4];
        blank_lz = 1'b1;
        @(negedge clk);
        value = 16'd7; hex_mode = 1'b0; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        wait_idle(found);
        repeat (2) @(negedge clk);
        for (int i = 0; i < 64; i++) begin
            if (an !== 4'hF && an !== 4'hE) bad++;
            if (an === 4'hE) n0++;
            @(negedge clk);
        end
        checks++;
        if (bad != 0 || n0 != 16) begin
            errors++;
            $display("FAIL lz_only_digit0: other-anode cycles=%0d an0 cycles=%0d, expected 0 and 16", bad, n0);
        end
        dp_mask = 4'b0100;
        repeat (2) @(negedge clk);
        for (int s = 0; s < 4; s++) cnt[s] = 0;
        for (int i = 0; i < 64; i++) begin
            for (int s = 0; s < 4; s++) if (an === 4'(~(4'b0001 << s))) cnt[s]++;
            @(negedge clk);
        end
        checks++;
        if (cnt[0] != 16 || cnt[1] != 16 || cnt[2] != 16 || cnt[3] != 0) begin
            errors++;
            $display("FAIL lz_dp_slots: counts %0d %0d %0d %0d, expected 16 16 16 0",
                     cnt[0], cnt[1], cnt[2], cnt[3]);
        end
        wait_an(4'b1110, found);
        checks++;
        if (!found || seg !== G7 || dp !== 1'b1) begin
            errors++;
            $display("FAIL lz_slot0: seg=%b dp=%b, expected seg=%b dp=1", seg, dp, G7);
        end
        wait_an(4'b1101, found);
        checks++;
        if (!found || seg !== G0 || dp !== 1'b1) begin
            errors++;
            $display("FAIL lz_slot1: seg=%b dp=%b, expected seg=%b dp=1", seg, dp, G0);
        end
        wait_an(4'b1011, found);
        checks++;
        if (!found || seg !== G0 || dp !== 1'b0) begin
            errors++;
            $display("FAIL lz_slot2_dp: seg=%b dp=%b, expected seg=%b dp=0", seg, dp, G0);
        end
        dp_mask = 4'b0000;
        blank_lz = 1'b0;
    endtask

    task automatic test_hex;
        bit found;
        int act = -1;
        logic [6:0] exp_g [4];
        exp_g[0] = GF; exp_g[1] = GE; exp_g[2] = GE; exp_g[3] = GB;
        @(negedge clk);
        value = 16'hBEEF; hex_mode = 1'b1; load = 1'b1;
        @(negedge clk);
        load = 1'b0; hex_mode = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL hex_no_busy: busy=%b, expected 0", busy);
        end
        @(negedge clk);
        for (int s = 0; s < 4; s++) if (an === 4'(~(4'b0001 << s))) act = s;
        checks++;
        if (act < 0) begin
            errors++;
            $display("FAIL hex_latency: no active anode (an=%b), expected one", an);
        end else if (seg !== exp_g[act]) begin
            errors++;
            $display("FAIL hex_latency: slot%0d seg=%b at T+2, expected %b", act, seg, exp_g[act]);
        end
        for (int s = 0; s < 4; s++) begin
            wait_an(4'(~(4'b0001 << s)), found);
            checks++;
            if (!found || seg !== exp_g[s] || dp !== 1'b1) begin
                errors++;
                $display("FAIL hex_slot%0d: found=%b seg=%b dp=%b, expected seg=%b dp=1",
                         s, found, seg, dp, exp_g[s]);
            end
        end
        checks++;
        if (an3 === 3'b111 || seg3 !== DASH || dp3 !== 1'b1) begin
            errors++;
            $display("FAIL hex_upper_nibble_ovf: an3=%b seg3=%b dp3=%b, expected active seg3=%b dp3=1",
                     an3, seg3, dp3, DASH);
        end
    endtask

    task automatic test_pwm;
        int on_cnt;
        int bad;
        logic [3:0] levels [3];
        int exp_on [3];
        levels[0] = 4'd3;  exp_on[0] = 16;
        levels[1] = 4'd0;  exp_on[1] = 4;
        levels[2] = 4'd15; exp_on[2] = 64;
        for (int l = 0; l < 3; l++) begin
            brightness = levels[l];
            repeat (2) @(negedge clk);
            on_cnt = 0; bad = 0;
            for (int i = 0; i < 64; i++) begin
                if (an !== 4'hF) on_cnt++;
                if (an !== 4'hF && an !== 4'hE && an !== 4'hD && an !== 4'hB && an !== 4'h7) bad++;
                @(negedge clk);
            end
            checks++;
            if (on_cnt != exp_on[l] || bad != 0) begin
                errors++;
                $display("FAIL pwm_b%0d: on=%0d illegal=%0d over 64 cycles, expected on=%0d illegal=0",
                         levels[l], on_cnt, bad, exp_on[l]);
            end
        end
    endtask

    task automatic test_blink;
        int gap = 0;
        int max_gap = 0;
        int n0 = 0;
        int n1 = 0;
        blink_mask = 4'b0001;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 192; i++) begin
            if (an === 4'hE) begin
                if (gap > max_gap) max_gap = gap;
                gap = 0;
            end else begin
                gap++;
            end
            if (i < 128 && an === 4'hE) n0++;
            if (i < 128 && an === 4'hD) n1++;
            @(negedge clk);
        end
        if (gap > max_gap) max_gap = gap;
        checks++;
        if (n0 != 16 || n1 != 32) begin
            errors++;
            $display("FAIL blink_counts: digit0=%0d digit1=%0d over 128 cycles, expected 16 and 32", n0, n1);
        end
        checks++;
        if (max_gap != 44) begin
            errors++;
            $display("FAIL blink_dark_gap: longest gap %0d, expected 44", max_gap);
        end
        blink_mask = 4'b0000;
    endtask

    task automatic test_reset_during_conv;
        bit found;
        @(negedge clk);
        value = 16'd4321; hex_mode = 1'b0; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        repeat (7) @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL rstconv_busy_before: busy=%b at T+8, expected 1", busy);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || an !== 4'hF || seg !== 7'h7F || dp !== 1'b1) begin
            errors++;
            $display("FAIL rstconv_outputs: busy=%b an=%h seg=%h dp=%b, expected 0 f 7f 1", busy, an, seg, dp);
        end
        rst = 1'b0;
        wait_an(4'b1110, found);
        checks++;
        if (!found || seg !== G0) begin
            errors++;
            $display("FAIL rstconv_slot0_zero: seg=%b, expected %b", seg, G0);
        end
        wait_an(4'b0111, found);
        checks++;
        if (!found || seg !== G0) begin
            errors++;
            $display("FAIL rstconv_slot3_zero: seg=%b, expected %b", seg, G0);
        end
    endtask

    initial begin
        rst = 1'b1; value = '0; load = 1'b0; hex_mode = 1'b0; blank_lz = 1'b0;
        dp_mask = '0; blink_mask = '0; brightness = 4'd15;
        test_reset;
        test_decimal_1234;
        test_decimal_overflow;
        test_leading_zero;
        test_hex;
        test_pwm;
        test_blink;
        test_reset_during_conv;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg_display_engine.md
# seg_display_engine

Parametrised N-digit multiplexed 7-segment display driver and the successor to the fixed 4-digit controller. It converts a latched binary value to BCD with an iterative, one-bit-per-cycle double-dabble, or shows it as raw hex. Display features are overflow dashes, leading-zero blanking, per-digit decimal points, per-digit blink and PWM brightness. It sits between the wave-generator control FSM and the board display pins.

## Interface
- `NUM_DIGITS`, 4: number of digits, 1..8.
- `BIN_WIDTH`, 16: width of `value`.
- `REFRESH_DIVIDER`, 100000: clocks per digit slot.
- `BRIGHT_BITS`, 4: width of the brightness control and PWM counter.
- `BLINK_SCANS`, 125: full scan frames per blink phase.
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `value`  in  BIN_WIDTH  binary value to display.
- `load`  in  1  capture pulse for `value` and `hex_mode`.
- `hex_mode`  in  1  1 = show nibbles as hex; 0 = show decimal.
- `blank_lz`  in  1  enables leading-zero blanking; sampled live.
- `dp_mask`  in  NUM_DIGITS  decimal point on per digit (bit i = digit i, digit 0 rightmost); live.
- `blink_mask`  in  NUM_DIGITS  per-digit blink enable; live.
- `brightness`  in  BRIGHT_BITS  PWM duty; live.
- `busy`  out  1  decimal conversion in progress.
- `seg`  out  7  {g,f,e,d,c,b,a}, active low.
- `an`  out  NUM_DIGITS  digit anodes, active low.
- `dp`  out  1  decimal point, active low.

## Operation
- **Capture**
  - `load` with `busy`=0: latch `value` and `hex_mode`.
  - `load` with `busy`=1: ignored entirely; no queueing.
- **Hex mode**
  - The display register takes `value` nibbles directly; `busy` is not asserted.
  - Nibbles above NUM_DIGITS are nonzero: overflow.
  - Missing upper nibbles read as 0.
- **Decimal mode, FSM IDLE -> CONV -> IDLE**
  - CONV runs exactly BIN_WIDTH cycles, MSB first.
  - The add-3 step applies to every BCD digit >= 5, then the shift.
  - The shift register has 4*NUM_DIGITS BCD bits plus a sticky overflow bit; the overflow bit is set when a 1 is shifted out of the top digit.
- **Display register update**
  - The register (digits, overflow) updates atomically, only at conversion end or on hex capture.
  - The old value is shown during CONV.
- **Scan**
  - The refresh counter wraps at REFRESH_DIVIDER-1 and advances the slot index 0..NUM_DIGITS-1, which wraps to 0.
  - A frame counter counts wraps of the slot index through 0; every BLINK_SCANS frames it toggles the blink phase, which resets to the on phase.
- **Per-slot digit i, priority order**
  1. overflow: seg=7'b0111111 (dash), dp off, digit not blanked.
  2. Blink off phase and `blink_mask[i]`: blanked.
  3. Leading-zero blank when all of these hold: `blank_lz`, i!=0, digits i..N-1 all zero, and `dp_mask[N-1:i]`==0 → blanked.
  4. Otherwise hex glyph 0-F (same glyph set as current design), with dp = !`dp_mask[i]`.
- **Blanked slot:** `an` all ones, seg=7'h7F, dp=1.
- **PWM**
  - A free-running BRIGHT_BITS counter; the anode is enabled only while pwm_cnt <= `brightness`.
  - Maximum code = always on; 0 = 1/2^BRIGHT_BITS duty.
  - seg and dp are unaffected by PWM.

## Timing
- **Reset values:** `an` all ones, seg=7'h7F, dp=1, busy=0; display register, counters and slot index 0; blink phase on; FSM IDLE.
- **Decimal load:**
  - `load` sampled high at edge T: busy=1 from T+1.
  - Display register updated and busy=0 at T+BIN_WIDTH+1.
  - A new load is accepted at T+BIN_WIDTH+1.
- **Hex load:** display register updated at T+1.
- **Output registration:** seg/an/dp are registered, one cycle after the slot index, display register or live input changes.
- **Reset during CONV:** conversion aborts; the display register is cleared to 0.
- **Simultaneous `load` and conversion end:** the load is ignored (busy still 1 that cycle).
- **Anode activity:** exactly one anode low at a time, or none.

## Test plan
Defaults unless stated: NUM_DIGITS=4, BIN_WIDTH=16, REFRESH_DIVIDER=4, BLINK_SCANS=2, brightness=15.
- Decimal 1234 → busy high for 16 cycles; slot 0 seg=7'b0011001 (4), slot 3 seg=7'b1111001 (1); old value shown during busy.
- Decimal 12345 → all four slots seg=7'b0111111, dp=1.
- `blank_lz`=1, 7 → only `an[0]` ever low. With `dp_mask`=4'b0100 → slots 0..2 active, showing "0.07" (digit 2 dp=0).
- Hex 0xBEEF → busy stays 0; glyphs F, E, E, b on slots 0..3, updated at T+1.
- brightness=3 → anode low 4 of every 16 cycles within a slot. `blink_mask`=4'b0001 → digit 0 is dark for alternate 2-frame periods.
- A second `load` at T+5 during CONV is ignored. Asserting `rst` at T+8 → busy=0 and display 0 next cycle; reset values are checked.
